// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction memory port, IF/ID outputs.
// The master side is the surrounding pipeline; the slave side is if_stage.
interface if_stage_if;
  logic        pc_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] PC4;
  logic [31:0] instr_code;
  logic        flush;
  logic        misalign_err;
  logic [15:0] fetch_count;
  logic        halted;

  modport master (
    output pc_write,
    output branch_taken,
    output branch_target,
    output jump,
    output jump_target,
    output imem_rdata,
    input  imem_addr,
    input  PC4,
    input  instr_code,
    input  flush,
    input  misalign_err,
    input  fetch_count,
    input  halted
  );

  modport slave (
    input  pc_write,
    input  branch_taken,
    input  branch_target,
    input  jump,
    input  jump_target,
    input  imem_rdata,
    output imem_addr,
    output PC4,
    output instr_code,
    output flush,
    output misalign_err,
    output fetch_count,
    output halted
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, redirect/stall handling, sticky misalign flag,
// saturating fetch counter. Optional halt-on-0xFFFFFFFF detection via IF_HALT_DETECT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.slave   bus
);

`ifdef IF_HALT_DETECT_EN
  typedef enum logic [1:0] {StFetch, StStall, StHalt} state_e;
`else
  typedef enum logic [0:0] {StFetch, StStall} state_e;
`endif

  localparam logic [31:0] HaltWord = 32'hFFFF_FFFF;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic        misalign_q, misalign_d;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic        pc_we;
  logic        halt_hit;

  // The EX branch is older than the ID jump, so it wins the target select.
  assign redirect   = bus.branch_taken | bus.jump;
  assign target_raw = bus.branch_taken ? bus.branch_target : bus.jump_target;
  assign target     = {target_raw[31:2], 2'b00};

`ifdef IF_HALT_DETECT_EN
  assign halt_hit = (state_q == StFetch) && !redirect && (bus.imem_rdata == HaltWord);
`else
  assign halt_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      fetch_count_q <= 16'h0000;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
      misalign_q    <= misalign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc_we   = 1'b0;
    if (redirect) begin
      // Redirect overrides a stall and leaves HALT.
      state_d = StFetch;
      pc_d    = target;
      pc_we   = 1'b1;
    end else if (halt_hit) begin
`ifdef IF_HALT_DETECT_EN
      state_d = StHalt;
`endif
    end else begin
      unique case (state_q)
`ifdef IF_HALT_DETECT_EN
        StHalt: state_d = StHalt;
`endif
        StFetch, StStall: begin
          if (bus.pc_write) begin
            state_d = StFetch;
            pc_d    = pc_q + 32'd4;
            pc_we   = 1'b1;
          end else begin
            state_d = StStall;
          end
        end
        default: state_d = StFetch;
      endcase
    end

    fetch_count_d = fetch_count_q;
    if (pc_we && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end

    misalign_d = misalign_q | (redirect & (target_raw[1:0] != 2'b00));
  end

  always_comb begin
    bus.imem_addr    = pc_q;
    bus.PC4          = pc_q + 32'd4;
    bus.flush        = redirect;
    bus.misalign_err = misalign_q;
    bus.fetch_count  = fetch_count_q;
`ifdef IF_HALT_DETECT_EN
    bus.halted       = (state_q == StHalt);
`else
    bus.halted       = 1'b0;
`endif
    bus.instr_code   = bus.halted ? 32'h0000_0000 : bus.imem_rdata;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-004 Port: pc_write  input  1  1 = advance PC; 0 = hold PC (load-use stall from hazard unit).
REQ-005 Port: branch_taken  input  1  taken branch resolved in EX (older instruction).
REQ-006 Port: branch_target  input  32  branch destination address.
REQ-007 Port: jump  input  1  jump decoded in ID (younger instruction).
REQ-008 Port: jump_target  input  32  jump destination address.
REQ-009 Port: imem_addr  output  32  instruction memory address, equal to the current PC.
REQ-010 Port: imem_rdata  input  32  instruction word, combinational read of imem_addr.
REQ-011 Port: PC4  output  32  current PC + 4, fed to the IF/ID register.
REQ-012 Port: instr_code  output  32  fetched instruction, fed to the IF/ID register.
REQ-013 Port: flush  output  1  clears the IF/ID register at the coming edge.
REQ-014 Port: misalign_err  output  1  sticky: a redirect target had nonzero bits [1:0].
REQ-015 Port: fetch_count  output  16  saturating count of PC advances.
REQ-016 Port: halted  output  1  fetch frozen by halt detection.

Function
REQ-017 The block SHALL hold a 32-bit PC register and a state register with states FETCH, STALL, HALT.
REQ-018 Redirect = branch_taken OR jump; the selected target is branch_target when branch_taken=1, otherwise jump_target (the EX branch is older and wins).
REQ-019 On a redirect, the PC SHALL load the target with bits [1:0] forced to 00 at the next edge, regardless of pc_write; the state becomes FETCH.
REQ-020 flush SHALL be 1 combinationally in every cycle where a redirect is present, and 0 otherwise; this discards the wrong-path word in the same cycle.
REQ-021 With no redirect and pc_write=1 in FETCH/STALL, the PC SHALL load PC+4 (modulo 2^32: 32'hFFFF_FFFC wraps to 0) and the state becomes FETCH.
REQ-022 With no redirect and pc_write=0, the PC SHALL hold and the state becomes STALL; imem_addr, PC4 and instr_code remain stable.
REQ-023 PC4 = PC + 4 and imem_addr = PC, both driven from the PC register; instr_code = imem_rdata, except in HALT where it is 32'h0 (NOP).
REQ-024 misalign_err SHALL set at the edge ending any redirect cycle whose selected target has bits [1:0] != 00, and clear only on reset.
REQ-025 fetch_count SHALL increment at each edge where the PC is written (advance or redirect) and saturate at 16'hFFFF.
REQ-026 Stall and redirect in the same cycle: the redirect is taken and fetch_count increments once.

Reset
REQ-027 On a rising edge with reset=0: PC=RESET_PC, state=FETCH, misalign_err=0, fetch_count=0, halted=0; reset overrides all other inputs, including an in-flight redirect or HALT.
REQ-028 flush is combinational and is not gated by reset.

Configuration
REQ-029 Macro IF_HALT_DETECT_EN: when defined, a fetched imem_rdata of 32'hFFFF_FFFF in FETCH with no redirect moves the state to HALT at the next edge. In HALT, PC holds, halted=1, instr_code=0 and fetch_count holds. A redirect leaves HALT for FETCH and loads the target.
REQ-030 When IF_HALT_DETECT_EN is undefined, halted SHALL be tied to 0, the HALT state SHALL be absent, and 32'hFFFF_FFFF SHALL be fetched as an ordinary word.

Verification
REQ-031 Reset sequence: RESET_PC=32'h0000_0040, reset=0 for 2 cycles, then pc_write=1 for 3 cycles -> imem_addr 0x40, 0x44, 0x48, 0x4C and fetch_count=3.
REQ-032 Load-use stall: pc_write=0 for 2 cycles at PC=0x10 -> imem_addr stays 0x10, flush=0, fetch_count unchanged; resumes to 0x14.
REQ-033 Priority and stall: branch_taken=1 with target 0x200, jump=1 with target 0x300, pc_write=0 in the same cycle -> flush=1 that cycle, next PC=0x200, fetch_count increments by 1.
REQ-034 Misalignment: jump=1 with jump_target=0x103 -> next PC=0x100 and misalign_err=1; it stays 1 until reset.
REQ-035 Wrap and saturation: PC=0xFFFF_FFFC with pc_write=1 -> PC=0 and PC4=4; with fetch_count preloaded near its limit, 70000 advances -> fetch_count=16'hFFFF.
REQ-036 Halt (IF_HALT_DETECT_EN defined): imem_rdata=32'hFFFF_FFFF at PC=0x20 -> halted=1, PC stays 0x20, instr_code=0. A later branch_taken to 0x80 -> halted=0, PC=0x80. With the macro undefined, the same stimulus -> PC=0x24.
